piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_cnt.sv | 29 ++
 rtl/piso_serializer.sv | 122 ++++++++++++
 tb/tb_piso_serializer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
// No latency: types and constant functions only.
// Backpressure: n/a. The PARITY state exists only when PISO_SERIALIZER_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef PISO_SERIALIZER_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  // Bit-counter width: wide enough to hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter with a zero flag; tracks the bits remaining in a frame.
// Latency: load and decrement take effect on the next rising edge.
// Backpressure: holds its value whenever dec is low; it saturates at zero.
module piso_bit_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  // Load has priority over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// PISO serializer: loads a WIDTH-bit word and emits it 1 bit per shift_en.
// Optional macro PISO_SERIALIZER_PARITY_EN appends an even-parity bit. Latency: the first bit is on out 1 cycle after accept.
// Backpressure: shift_en=0 stalls the frame. in_ready opens on the consumed last bit, so frames run back to back.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    count;
  logic             zero;
  logic             head;
  logic             accept;
  logic             dec;
  logic             last_data;

  assign head         = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  assign sreg_shifted = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign last_data    = (state == SHIFT) && zero;
  assign out_valid    = (state != IDLE);
  assign busy         = out_valid;
  assign in_ready     = (state == IDLE) || (last && shift_en);
  assign accept       = in_valid && in_ready;
  assign dec          = (state == SHIFT) && shift_en && !zero;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par;
  assign last = (state == PARITY);
  assign out  = (state == PARITY) ? par : head;
`else
  assign last = last_data;
  assign out  = head;
`endif

  piso_bit_cnt #(.CW(CW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (dec),
    .count    (count),
    .zero     (zero)
  );

  // Frame FSM: load on accept, shift on each consume, and clear the register on the way back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= in_data;
`ifdef PISO_SERIALIZER_PARITY_EN
            par   <= ^in_data;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (!zero) begin
              sreg <= sreg_shifted;
            end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
              sreg  <= '0;
              state <= PARITY;
`else
              if (accept) begin
                sreg <= in_data;
              end else begin
                sreg  <= '0;
                state <= IDLE;
              end
`endif
            end
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (shift_en) begin
            if (accept) begin
              sreg  <= in_data;
              par   <= ^in_data;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          sreg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance share the same stimulus.
// Sampling happens 1 time unit after each rising edge, and inputs change only after those checks.
// With PISO_SERIALIZER_PARITY_EN defined, every frame grows by one parity bit.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       shift_en;
  logic       m_ready, m_out, m_valid, m_last, m_busy;
  logic       l_ready, l_out, l_valid, l_last, l_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready), .in_data(in_data),
    .shift_en(shift_en), .out(m_out), .out_valid(m_valid), .last(m_last), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_ready), .in_data(in_data),
    .shift_en(shift_en), .out(l_out), .out_valid(l_valid), .last(l_last), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame bit k: data bits in the chosen order, then the parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
    if (k >= 8) return ^w;
    return msb ? w[7-k] : w[k];
  endfunction

  task automatic chk_bit(input string tag, input logic [7:0] w, input int k);
    logic lst;
    lst = (k == NB-1);
    chk({tag, " m_out"},   m_out,   exp_bit(w, k, 1'b1));
    chk({tag, " l_out"},   l_out,   exp_bit(w, k, 1'b0));
    chk({tag, " m_valid"}, m_valid, 1'b1);
    chk({tag, " l_valid"}, l_valid, 1'b1);
    chk({tag, " m_busy"},  m_busy,  1'b1);
    chk({tag, " m_last"},  m_last,  lst);
    chk({tag, " l_last"},  l_last,  lst);
    chk({tag, " m_ready"}, m_ready, lst && shift_en);
    chk({tag, " l_ready"}, l_ready, lst && shift_en);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " m_out"},   m_out,   1'b0);
    chk({tag, " l_out"},   l_out,   1'b0);
    chk({tag, " m_valid"}, m_valid, 1'b0);
    chk({tag, " l_valid"}, l_valid, 1'b0);
    chk({tag, " m_last"},  m_last,  1'b0);
    chk({tag, " l_last"},  l_last,  1'b0);
    chk({tag, " m_busy"},  m_busy,  1'b0);
    chk({tag, " l_busy"},  l_busy,  1'b0);
    chk({tag, " m_ready"}, m_ready, 1'b1);
    chk({tag, " l_ready"}, l_ready, 1'b1);
  endtask

  // Accept w on the next edge and play the whole frame with shift_en held high.
  task automatic full_frame(input string tag, input logic [7:0] w);
    in_valid = 1'b1; in_data = w; shift_en = 1'b1;
    step();
    in_valid = 1'b0; in_data = ~w;
    for (int k = 0; k < NB; k++) begin
      chk_bit($sformatf("%s b%0d", tag, k), w, k);
      step();
    end
    chk_idle({tag, " end"});
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; shift_en = 1'b0;
    #3;
    chk_idle("reset");
    step(); step();
    rst = 1'b1;
    step();
    chk_idle("post_reset");

    // A5 reads 1,0,1,0,0,1,0,1 in both bit orders.
    full_frame("a5", 8'hA5);

    // Back to back: FF then 00 with in_valid held; in_valid is ignored during the FF frame.
    in_valid = 1'b1; in_data = 8'hFF; shift_en = 1'b1;
    step();
    in_data = 8'h00;
    for (int k = 0; k < NB; k++) begin
      chk_bit($sformatf("b2b_ff b%0d", k), 8'hFF, k);
      step();
    end
    for (int k = 0; k < NB; k++) begin
      chk_bit($sformatf("b2b_00 b%0d", k), 8'h00, k);
      if (k == NB-1) in_valid = 1'b0;
      step();
    end
    chk_idle("b2b end");

    // Stall on bit 2 of 3C for 5 cycles, with an ignored in_valid pulse during the stall.
    in_valid = 1'b1; in_data = 8'h3C; shift_en = 1'b1;
    step();
    in_valid = 1'b0;
    chk_bit("stall b0", 8'h3C, 0);
    step();
    chk_bit("stall b1", 8'h3C, 1);
    shift_en = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bit($sformatf("stall hold%0d", i), 8'h3C, 1);
    end
    shift_en = 1'b1; in_valid = 1'b0;
    step();
    for (int k = 2; k < NB; k++) begin
      chk_bit($sformatf("stall b%0d", k), 8'h3C, k);
      step();
    end
    chk_idle("stall end");

    // Reset mid-frame after bit 4 of 96, then send a clean frame of 01.
    in_valid = 1'b1; in_data = 8'h96; shift_en = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_bit($sformatf("rst96 b%0d", k), 8'h96, k);
      if (k < 3) step();
    end
    rst = 1'b0;
    #1;
    chk_idle("midreset");
    step(); step();
    rst = 1'b1;
    step();
    chk_idle("after_release");
    full_frame("post01", 8'h01);

    // 07: with parity the 9th bit is 1.
    full_frame("f07", 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
